// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, schedule sigma functions and the schedule length.
package sha256_pkg;

  localparam int unsigned SHA256_WORDS = 64;

  typedef logic [31:0] sha256_word_t;

  typedef enum logic {StIdle, StIssue} issue_state_e;

  function automatic sha256_word_t sha256_sigma0(sha256_word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic sha256_word_t sha256_sigma1(sha256_word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Next message-schedule word from a 16-word window whose oldest entry is w_t0.
module sha256_w_next
  import sha256_pkg::*;
(
  input  logic [31:0] w_t0,
  input  logic [31:0] w_t1,
  input  logic [31:0] w_t9,
  input  logic [31:0] w_t14,
  output logic [31:0] w_next
);

  assign w_next = sha256_sigma1(w_t14) + w_t9 + sha256_sigma0(w_t1) + w_t0;

endmodule

// File: rtl/sha256_w_stream_issuer.sv
// Accepts a 512-bit block and streams W0..W(ROUNDS-1) with valid/ready, using a rolling
// 16-word window. ROUNDS must lie in 16..64.
module sha256_w_stream_issuer
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA256_WORDS
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] block_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy
);

  localparam logic [5:0] LastIdx = 6'(ROUNDS - 1);

  issue_state_e state_q, state_d;
  logic [31:0]  win_q [16];
  logic [31:0]  win_d [16];
  logic [5:0]   idx_q, idx_d;
  logic [31:0]  w_new;
  logic         word_hs, accept;

  sha256_w_next u_w_next (
    .w_t0   (win_q[0]),
    .w_t1   (win_q[1]),
    .w_t9   (win_q[9]),
    .w_t14  (win_q[14]),
    .w_next (w_new)
  );

  assign w_valid   = (state_q == StIssue);
  assign busy      = w_valid;
  assign w_out     = win_q[0];
  assign w_idx     = idx_q;
  assign w_last    = w_valid && (idx_q == LastIdx);
  assign word_hs   = w_valid && w_ready;
  // The final handshake of a block doubles as a load slot so blocks chain without a bubble.
  assign blk_ready = (state_q == StIdle) || (word_hs && w_last);
  assign accept    = blk_valid && blk_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    if (accept) begin
      state_d = StIssue;
      idx_d   = '0;
      for (int i = 0; i < 16; i++) begin
        win_d[i] = block_in[511 - 32*i -: 32];
      end
    end else if (word_hs) begin
      if (w_last) begin
        state_d = StIdle;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 6'd1;
        for (int i = 0; i < 15; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[15] = w_new;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_sha256_w_stream_issuer.sv
// Directed bench for sha256_w_stream_issuer: full 64-round and reduced 16-round instances.
module tb_sha256_w_stream_issuer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         blk_valid_a, blk_valid_b;
  logic [511:0] block_in;
  logic         w_ready;

  logic         a_blk_ready, a_w_valid, a_w_last, a_busy;
  logic [31:0]  a_w_out;
  logic [5:0]   a_w_idx;
  logic         b_blk_ready, b_w_valid, b_w_last, b_busy;
  logic [31:0]  b_w_out;
  logic [5:0]   b_w_idx;

  bit           sel;
  logic         m_blk_ready, m_w_valid, m_w_last, m_busy;
  logic [31:0]  m_w_out;
  logic [5:0]   m_w_idx;

  assign m_blk_ready = sel ? b_blk_ready : a_blk_ready;
  assign m_w_valid   = sel ? b_w_valid   : a_w_valid;
  assign m_w_last    = sel ? b_w_last    : a_w_last;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_w_out     = sel ? b_w_out     : a_w_out;
  assign m_w_idx     = sel ? b_w_idx     : a_w_idx;

  always #5 CLK = ~CLK;

  sha256_w_stream_issuer #(.ROUNDS(64)) dut_a (
    .CLK       (CLK),
    .RST       (RST),
    .blk_valid (blk_valid_a),
    .blk_ready (a_blk_ready),
    .block_in  (block_in),
    .w_valid   (a_w_valid),
    .w_ready   (w_ready),
    .w_out     (a_w_out),
    .w_idx     (a_w_idx),
    .w_last    (a_w_last),
    .busy      (a_busy)
  );

  sha256_w_stream_issuer #(.ROUNDS(16)) dut_b (
    .CLK       (CLK),
    .RST       (RST),
    .blk_valid (blk_valid_b),
    .blk_ready (b_blk_ready),
    .block_in  (block_in),
    .w_valid   (b_w_valid),
    .w_ready   (w_ready),
    .w_out     (b_w_out),
    .w_idx     (b_w_idx),
    .w_last    (b_w_last),
    .busy      (b_busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          hs_cnt, seq_err, stall_err;
  logic [31:0] got_w [64];
  logic [31:0] exp_w [64];
  logic [31:0] s1_w  [64];

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ss0(logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic gen_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
  endtask

  // Runs the word handshake from a negedge until the last word is taken, the stream ends,
  // or (stop_idx >= 0) the word with that index is showing; in that case it is left unaccepted.
  task automatic collect(input bit rnd, input int rounds, input int stop_idx);
    logic [31:0] pw;
    logic [5:0]  pi;
    bit          pstall, done;
    pw = '0; pi = '0; pstall = 1'b0; done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (pstall && (m_w_out !== pw || m_w_idx !== pi)) stall_err++;
      if (!m_w_valid) begin
        seq_err++;
        done = 1'b1;
      end else if (stop_idx >= 0 && int'(m_w_idx) == stop_idx) begin
        w_ready = 1'b0;
        done    = 1'b1;
      end else begin
        w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (w_ready) begin
          if (hs_cnt < 64) got_w[hs_cnt] = m_w_out;
          if (int'(m_w_idx) != hs_cnt) seq_err++;
          if (m_w_last != (hs_cnt == rounds - 1)) seq_err++;
          if (m_w_last) done = 1'b1;
          hs_cnt++;
        end
        pstall = !w_ready;
        pw     = m_w_out;
        pi     = m_w_idx;
        @(negedge CLK);
      end
    end
    if (!done) check("collect_timeout", 32'd1, 32'd0);
  endtask

  task automatic compare_model(input string name, input int n);
    int bad = 0;
    for (int t = 0; t < n; t++) if (got_w[t] !== exp_w[t]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  // Loads the abc block into the 64-round instance and streams it out fully.
  task automatic run_abc(input string pfx, input bit rnd, input logic [511:0] blk);
    sel = 1'b0;
    gen_model(blk);
    block_in = blk;
    blk_valid_a = 1'b1;
    check({pfx, "_blk_ready_idle"}, 32'(m_blk_ready), 32'd1);
    @(negedge CLK);
    blk_valid_a = 1'b0;
    check({pfx, "_first_valid"}, 32'(m_w_valid), 32'd1);
    check({pfx, "_first_idx"}, 32'(m_w_idx), 32'd0);
    hs_cnt = 0; seq_err = 0; stall_err = 0;
    collect(rnd, 64, -1);
    check({pfx, "_handshakes"}, 32'(hs_cnt), 32'd64);
    check({pfx, "_idx_last_seq"}, 32'(seq_err), 32'd0);
    check({pfx, "_stall_stable"}, 32'(stall_err), 32'd0);
    check({pfx, "_valid_after"}, 32'(m_w_valid), 32'd0);
    check({pfx, "_busy_after"}, 32'(m_busy), 32'd0);
    compare_model({pfx, "_words"}, 64);
  endtask

  logic [511:0] abc, blk2, ones;

  initial begin
    abc  = {32'h61626380, 448'd0, 32'h00000018};
    ones = '1;
    for (int i = 0; i < 16; i++) blk2[511 - 32*i -: 32] = 32'h01234567 + 32'(i) * 32'h10203040;
    vt[0] = '{"W0",  0,  32'h61626380};
    vt[1] = '{"W1",  1,  32'h00000000};
    vt[2] = '{"W14", 14, 32'h00000000};
    vt[3] = '{"W15", 15, 32'h00000018};
    vt[4] = '{"W16", 16, 32'h61626380};
    vt[5] = '{"W17", 17, 32'h000F0000};

    sel = 1'b0;
    RST = 1'b0; blk_valid_a = 1'b0; blk_valid_b = 1'b0; w_ready = 1'b0; block_in = '0;
    repeat (2) @(negedge CLK);
    check("rst_w_valid", 32'(m_w_valid), 32'd0);
    check("rst_w_last", 32'(m_w_last), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_w_idx", 32'(m_w_idx), 32'd0);
    check("rst_w_out", m_w_out, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_blk_ready", 32'(m_blk_ready), 32'd1);

    // 1: abc block, no backpressure
    run_abc("s1", 1'b0, abc);
    for (int i = 0; i < 6; i++) check({"s1_", vt[i].name}, got_w[vt[i].idx], vt[i].exp);
    for (int t = 0; t < 64; t++) s1_w[t] = got_w[t];

    // 2: random backpressure, same word sequence
    run_abc("s2", 1'b1, abc);
    begin
      int bad = 0;
      for (int t = 0; t < 64; t++) if (got_w[t] !== s1_w[t]) bad++;
      check("s2_same_as_s1", 32'(bad), 32'd0);
    end
    w_ready = 1'b1;

    // 3: back-to-back blocks with blk_valid held high
    gen_model(blk2);
    block_in = abc; blk_valid_a = 1'b1;
    @(negedge CLK);
    block_in = blk2;
    hs_cnt = 0; seq_err = 0; stall_err = 0;
    collect(1'b0, 64, -1);
    check("s3_first_hs", 32'(hs_cnt), 32'd64);
    check("s3_no_bubble_valid", 32'(m_w_valid), 32'd1);
    check("s3_idx_restart", 32'(m_w_idx), 32'd0);
    check("s3_second_w0", m_w_out, exp_w[0]);
    blk_valid_a = 1'b0;
    hs_cnt = 0;
    collect(1'b0, 64, -1);
    check("s3_second_hs", 32'(hs_cnt), 32'd64);
    check("s3_seq", 32'(seq_err), 32'd0);
    compare_model("s3_second_words", 64);

    // 4: blk_valid pulsed mid-block at w_idx=20
    gen_model(abc);
    block_in = abc; blk_valid_a = 1'b1;
    @(negedge CLK);
    blk_valid_a = 1'b0;
    hs_cnt = 0; seq_err = 0; stall_err = 0;
    collect(1'b0, 64, 20);
    block_in = ones; blk_valid_a = 1'b1;
    check("s4_blk_ready_mid", 32'(m_blk_ready), 32'd0);
    @(negedge CLK);
    blk_valid_a = 1'b0;
    check("s4_idx_held", 32'(m_w_idx), 32'd20);
    collect(1'b0, 64, -1);
    check("s4_hs", 32'(hs_cnt), 32'd64);
    check("s4_seq", 32'(seq_err), 32'd0);
    compare_model("s4_words", 64);

    // 5: asynchronous reset at w_idx=30
    block_in = abc; blk_valid_a = 1'b1;
    @(negedge CLK);
    blk_valid_a = 1'b0;
    hs_cnt = 0; seq_err = 0; stall_err = 0;
    collect(1'b0, 64, 30);
    check("s5_at_idx30", 32'(m_w_idx), 32'd30);
    w_ready = 1'b1;
    #2 RST = 1'b0;
    #1;
    check("s5_rst_valid", 32'(m_w_valid), 32'd0);
    check("s5_rst_busy", 32'(m_busy), 32'd0);
    check("s5_rst_idx", 32'(m_w_idx), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("s5_blk_ready", 32'(m_blk_ready), 32'd1);
    run_abc("s5", 1'b0, abc);
    for (int i = 0; i < 6; i++) check({"s5_", vt[i].name}, got_w[vt[i].idx], vt[i].exp);

    // 6: ROUNDS=16 instance with all-ones block
    sel = 1'b1;
    block_in = ones; blk_valid_b = 1'b1;
    check("s6_blk_ready", 32'(m_blk_ready), 32'd1);
    @(negedge CLK);
    blk_valid_b = 1'b0;
    hs_cnt = 0; seq_err = 0; stall_err = 0;
    collect(1'b0, 16, -1);
    check("s6_hs", 32'(hs_cnt), 32'd16);
    check("s6_seq_last15", 32'(seq_err), 32'd0);
    begin
      int bad = 0;
      for (int t = 0; t < 16; t++) if (got_w[t] !== 32'hFFFFFFFF) bad++;
      check("s6_all_ones", 32'(bad), 32'd0);
    end
    check("s6_valid_after", 32'(m_w_valid), 32'd0);
    check("s6_busy_after", 32'(m_busy), 32'd0);
    check("s6_blk_ready_after", 32'(m_blk_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
